ps2_kbd_rx: RTL and testbench

PS/2 keyboard receiver that drives the keyboard read interface used by the MMIO read path (kb_rdata, kb_ready, sig_rd_kb).
- Samples the external PS/2 clock/data lines and deframes 11-bit device-to-host frames.
- Checks odd parity and buffers good scan codes in a small FIFO.
- Presents the FIFO head to the bus; the bus pops it with sig_rd_kb.

---
 rtl/ps2_kbd_rx_pkg.sv | 13 +
 rtl/ps2_kbd_rx_sync_fifo.sv | 50 +++++
 rtl/ps2_kbd_rx.sv | 139 +++++++++++++
 tb/tb_ps2_kbd_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: scan-code width and FSM states.
package ps2_kbd_rx_pkg;

   localparam int KbWidth = 8;

   typedef enum logic [1:0] {
      KB_IDLE,
      KB_DATA,
      KB_PARITY,
      KB_STOP
   } kb_state_e;

endpackage

// File: rtl/ps2_kbd_rx_sync_fifo.sv
// Single-clock FIFO; head is presented combinationally and reads as zero when empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   // A pop on a full FIFO frees the slot the simultaneous push lands in.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 device-to-host receiver: sync, falling-edge detect, frame FSM with timeout,
// odd-parity check and scan-code FIFO exposed to the MMIO read path.
module ps2_kbd_rx
   import ps2_kbd_rx_pkg::*;
#(
   parameter int KB_WIDTH    = KbWidth,
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ps2_clk,
   input  logic                ps2_data,
   input  logic                sig_rd_kb,
   output logic [KB_WIDTH-1:0] kb_rdata,
   output logic                kb_ready,
   output logic                kb_overflow,
   output logic                kb_frame_err
);

   localparam int CW = $clog2(KB_WIDTH);
   localparam int TW = $clog2(TIMEOUT_CYC);

   logic                clk_s1_q, clk_s2_q, clk_prev_q;
   logic                dat_s1_q, dat_s2_q;
   logic                fe;
   kb_state_e           state_q, state_d;
   logic [KB_WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                par_q, par_d;
   logic                push_q, push_d;
   logic [TW-1:0]       tmo_q, tmo_d;
   logic                err_set;
   logic                err_q, ovf_q;
   logic                fifo_empty, fifo_full;

   assign fe = ~clk_s2_q & clk_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
      end else begin
         clk_s1_q   <= ps2_clk;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= ps2_data;
         dat_s2_q   <= dat_s1_q;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      push_d  = 1'b0;
      err_set = 1'b0;
      tmo_d   = (state_q == KB_IDLE) ? '0 : tmo_q + 1'b1;
      // Timeout wins over a coincident falling edge.
      if (state_q != KB_IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
         state_d = KB_IDLE;
         cnt_d   = '0;
         tmo_d   = '0;
         err_set = 1'b1;
      end else if (fe) begin
         tmo_d = '0;
         case (state_q)
            KB_IDLE: begin
               if (!dat_s2_q) begin
                  state_d = KB_DATA;
                  cnt_d   = '0;
               end else begin
                  err_set = 1'b1;
               end
            end
            KB_DATA: begin
               shift_d = {dat_s2_q, shift_q[KB_WIDTH-1:1]};
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == CW'(KB_WIDTH - 1)) state_d = KB_PARITY;
            end
            KB_PARITY: begin
               par_d   = dat_s2_q;
               state_d = KB_STOP;
            end
            KB_STOP: begin
               if (dat_s2_q && (^shift_q ^ par_q)) push_d = 1'b1;
               else                                err_set = 1'b1;
               state_d = KB_IDLE;
            end
            default: state_d = KB_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= KB_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
         push_q  <= 1'b0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
         push_q  <= push_d;
         tmo_q   <= tmo_d;
         err_q   <= err_q | err_set;
         ovf_q   <= ovf_q | (push_q & fifo_full & ~sig_rd_kb);
      end
   end

   sync_fifo #(
      .WIDTH (KB_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_q),
      .pop   (sig_rd_kb),
      .din   (shift_q),
      .dout  (kb_rdata),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign kb_ready     = ~fifo_empty;
   assign kb_overflow  = ovf_q;
   assign kb_frame_err = err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: frames driven on the PS/2 pins, outputs checked inline.
module tb_ps2_kbd_rx;

   localparam int TMO = 3000;
   localparam int HF  = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       sig_rd_kb = 1'b0;
   logic [7:0] kb_rdata;
   logic       kb_ready, kb_overflow, kb_frame_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ps2_kbd_rx #(
      .KB_WIDTH    (8),
      .FIFO_DEPTH  (8),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .sig_rd_kb    (sig_rd_kb),
      .kb_rdata     (kb_rdata),
      .kb_ready     (kb_ready),
      .kb_overflow  (kb_overflow),
      .kb_frame_err (kb_frame_err)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; sig_rd_kb = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(3);
   endtask

   // lat: clk edges from the stop-bit pin fall until kb_ready first rises (-1 if not seen)
   task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits,
                             input int half, input logic pop_on_push, output int lat);
      logic [10:0] fr;
      logic        was;
      fr  = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      lat = -1;
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         step(half);
         ps2_clk = 1'b0;
         was = kb_ready;
         for (int k = 1; k <= half; k++) begin
            step(1);
            if (i == 10) begin
               if (pop_on_push && k == 3) sig_rd_kb = 1'b1;
               if (k == 4) sig_rd_kb = 1'b0;
               if (kb_ready && !was && lat < 0) lat = k;
            end
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic pop_one();
      sig_rd_kb = 1'b1;
      step(1);
      sig_rd_kb = 1'b0;
      step(1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(2);
      n_cmp++;
      if ({kb_ready, kb_overflow, kb_frame_err} !== 3'b000 || kb_rdata !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_outputs: got rdy=%b ovf=%b err=%b data=%h, want all 0",
                  kb_ready, kb_overflow, kb_frame_err, kb_rdata);
      end
      do_reset();
   endtask

   task automatic test_single();
      int lat;
      do_reset();
      send_frame(8'h1C, 1'b0, 11, 1000, 1'b0, lat);
      n_cmp++;
      if (lat !== 4) begin n_bad++; $display("FAIL single_latency: got %0d want 4", lat); end
      n_cmp++;
      if (kb_ready !== 1'b1 || kb_rdata !== 8'h1C) begin
         n_bad++; $display("FAIL single_data: got rdy=%b data=%h want rdy=1 data=1c", kb_ready, kb_rdata);
      end
      n_cmp++;
      if (kb_frame_err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", kb_frame_err); end
   endtask

   task automatic test_parity();
      int lat;
      do_reset();
      send_frame(8'h1C, 1'b1, 11, HF, 1'b0, lat);
      step(10);
      n_cmp++;
      if (kb_ready !== 1'b0 || kb_rdata !== 8'h00) begin
         n_bad++; $display("FAIL parity_nopush: got rdy=%b data=%h want rdy=0 data=00", kb_ready, kb_rdata);
      end
      n_cmp++;
      if (kb_frame_err !== 1'b1) begin n_bad++; $display("FAIL parity_err: got %b want 1", kb_frame_err); end
   endtask

   task automatic test_overflow();
      int lat;
      do_reset();
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 11, HF, 1'b0, lat);
      step(4);
      n_cmp++;
      if (kb_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", kb_overflow); end
      n_cmp++;
      if (kb_frame_err !== 1'b0) begin n_bad++; $display("FAIL ovf_err: got %b want 0", kb_frame_err); end
      for (int i = 1; i <= 8; i++) begin
         n_cmp++;
         if (kb_ready !== 1'b1 || kb_rdata !== 8'(i)) begin
            n_bad++; $display("FAIL ovf_read%0d: got rdy=%b data=%h want rdy=1 data=%h", i, kb_ready, kb_rdata, 8'(i));
         end
         pop_one();
      end
      n_cmp++;
      if (kb_ready !== 1'b0 || kb_rdata !== 8'h00) begin
         n_bad++; $display("FAIL ovf_drained: got rdy=%b data=%h want rdy=0 data=00", kb_ready, kb_rdata);
      end
      pop_one();
      n_cmp++;
      if (kb_ready !== 1'b0 || kb_rdata !== 8'h00) begin
         n_bad++; $display("FAIL empty_pop: got rdy=%b data=%h want rdy=0 data=00", kb_ready, kb_rdata);
      end
   endtask

   task automatic test_full_pushpop();
      int         lat;
      logic [7:0] exp_b [8];
      do_reset();
      for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 11, HF, 1'b0, lat);
      send_frame(8'hF0, 1'b0, 11, HF, 1'b1, lat);
      step(2);
      n_cmp++;
      if (kb_overflow !== 1'b0) begin n_bad++; $display("FAIL full_pp_ovf: got %b want 0", kb_overflow); end
      exp_b = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hF0};
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (kb_ready !== 1'b1 || kb_rdata !== exp_b[i]) begin
            n_bad++; $display("FAIL full_pp_read%0d: got rdy=%b data=%h want rdy=1 data=%h", i, kb_ready, kb_rdata, exp_b[i]);
         end
         pop_one();
      end
      n_cmp++;
      if (kb_ready !== 1'b0) begin n_bad++; $display("FAIL full_pp_count: got rdy=%b want 0", kb_ready); end
   endtask

   task automatic test_timeout();
      int lat;
      do_reset();
      send_frame(8'h2A, 1'b0, 5, HF, 1'b0, lat);
      step(5);
      n_cmp++;
      if (kb_frame_err !== 1'b0) begin n_bad++; $display("FAIL tmo_early: got %b want 0", kb_frame_err); end
      step(TMO + 20);
      n_cmp++;
      if (kb_frame_err !== 1'b1 || kb_ready !== 1'b0) begin
         n_bad++; $display("FAIL tmo_abort: got err=%b rdy=%b want err=1 rdy=0", kb_frame_err, kb_ready);
      end
      send_frame(8'h2A, 1'b0, 11, HF, 1'b0, lat);
      step(2);
      n_cmp++;
      if (kb_ready !== 1'b1 || kb_rdata !== 8'h2A) begin
         n_bad++; $display("FAIL tmo_recover: got rdy=%b data=%h want rdy=1 data=2a", kb_ready, kb_rdata);
      end
   endtask

   task automatic test_reset_midframe();
      int lat;
      do_reset();
      send_frame(8'h11, 1'b0, 11, HF, 1'b0, lat);
      send_frame(8'h22, 1'b0, 11, HF, 1'b0, lat);
      send_frame(8'h33, 1'b0, 11, HF, 1'b0, lat);
      n_cmp++;
      if (kb_ready !== 1'b1 || kb_rdata !== 8'h11) begin
         n_bad++; $display("FAIL rst_pre: got rdy=%b data=%h want rdy=1 data=11", kb_ready, kb_rdata);
      end
      send_frame(8'h77, 1'b0, 5, HF, 1'b0, lat);
      rst_n = 1'b0;
      #2;
      n_cmp++;
      if ({kb_ready, kb_overflow, kb_frame_err} !== 3'b000 || kb_rdata !== 8'h00) begin
         n_bad++;
         $display("FAIL rst_async: got rdy=%b ovf=%b err=%b data=%h want all 0",
                  kb_ready, kb_overflow, kb_frame_err, kb_rdata);
      end
      step(2);
      rst_n = 1'b1;
      step(2);
      send_frame(8'h5A, 1'b0, 11, HF, 1'b0, lat);
      step(2);
      n_cmp++;
      if (kb_ready !== 1'b1 || kb_rdata !== 8'h5A || kb_frame_err !== 1'b0) begin
         n_bad++; $display("FAIL rst_recover: got rdy=%b data=%h err=%b want rdy=1 data=5a err=0",
                           kb_ready, kb_rdata, kb_frame_err);
      end
      pop_one();
      n_cmp++;
      if (kb_ready !== 1'b0) begin n_bad++; $display("FAIL rst_single: got rdy=%b want 0", kb_ready); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_parity();
      test_overflow();
      test_full_pushpop();
      test_timeout();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
